serial_adder_ctrl: RTL

Bit-serial adder controller that sequences one full-adder cell over a WIDTH-bit operand pair, LSB first, one bit per clock. It latches the operands on a start request, iterates the cell while carrying the carry in a register, and presents the WIDTH-bit sum and final carry with a one-cycle done pulse. It sits between the board's switch/button front end and the LED/display output path. It lets the team add wide operands with a single 1-bit adder cell.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/serial_adder_ctrl_cell.sv | 19 +
 rtl/serial_adder_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_pkg;

  // Controller states; 2'd3 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned WidthMin = 1;
  localparam int unsigned WidthMax = 32;

  // Legal operand widths for the controller.
  function automatic bit width_ok(int unsigned w);
    return (w >= WidthMin) && (w <= WidthMax);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle between the front end and the serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );

endinterface

// File: rtl/serial_adder_ctrl_cell.sv
// Single-bit full adder cell, purely combinational.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic w_p;

  // Propagate/generate form keeps the carry as pure logic.
  always_comb begin
    w_p   = a ^ b;
    sum   = w_p ^ c_in;
    c_out = (a & b) | (w_p & c_in);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell iterated LSB first over WIDTH bits.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_bad
    $error("serial_adder_ctrl: WIDTH out of range 1..32");
  end

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_nxt;
  logic [CntW-1:0]  r_cnt;
  logic             r_cy;
  logic             r_cout;
  logic             w_accept;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;

  full_adder_cell u_cell (
    .a     (r_sa[0]),
    .b     (r_sb[0]),
    .c_in  (r_cy),
    .sum   (w_fa_sum),
    .c_out (w_fa_cout)
  );

  // Decode accept and final-bit conditions from the current state.
  always_comb begin
    w_accept = (r_state == S_IDLE) && bus.start;
    w_last   = (r_state == S_RUN) && (r_cnt == CntLast);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to idle.
  always_comb begin
    w_state_d = S_IDLE;
    unique case (r_state)
      S_IDLE:  w_state_d = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_state_d = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    w_sum_nxt            = r_sum >> 1;
    w_sum_nxt[WIDTH-1]   = w_fa_sum;
  end

  // Datapath: capture on accept, shift one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_cy   <= 1'b0;
      r_cout <= 1'b0;
    end else if (w_accept) begin
      r_sa   <= bus.a;
      r_sb   <= bus.b;
      r_cy   <= bus.c_in;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sum <= w_sum_nxt;
      r_cy  <= w_fa_cout;
      r_cnt <= r_cnt + CntW'(1);
      if (w_last) begin
        r_cout <= w_fa_cout;
      end
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  always_comb begin
    bus.busy  = (r_state == S_RUN);
    bus.done  = (r_state == S_DONE);
    bus.sum   = r_sum;
    bus.c_out = r_cout;
  end

endmodule
